reg_wb_scheduler: RTL

Write-port scheduler for the 32 x 32-bit register file. It shares the file's single write port between the ALU writeback path and the memory-load writeback path. Load results are buffered in a small FIFO, and arbitration uses ALU priority with a starvation guard. A per-register busy scoreboard lets the decode stage detect hazards against outstanding loads. Its registered outputs drive the register file's IN, INADDRESS and WRITE directly.

---
 rtl/reg_wb_pkg.sv | 20 ++
 rtl/reg_wb_scheduler_if.sv | 38 +++
 rtl/wb_fifo.sv | 56 +++++
 rtl/reg_wb_scheduler.sv | 96 +++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared parameters and types for the register-file write-port scheduler.
//   NREG, AW, DW     : register file geometry
//   DEPTH            : load-writeback FIFO depth (power of two, >= 2)
//   STARVE_LIMIT     : ALU wins tolerated before the FIFO is forced a grant
//   wb_entry_t       : one pending writeback {addr, data}
package reg_wb_pkg;

    localparam int unsigned NREG         = 32;
    localparam int unsigned AW           = 5;
    localparam int unsigned DW           = 32;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 3;
    localparam int unsigned SCW          = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_scheduler_if.sv
// Bundle of all scheduler-facing signals except clock and reset.
//   master : upstream pipeline / register-file side (drives requests, reads results)
//   slave  : the scheduler itself
interface reg_wb_scheduler_if;
    import reg_wb_pkg::*;

    logic            alu_valid;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;
    logic            issue_load;
    logic [AW-1:0]   issue_addr;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   rd_addr;
    logic            hazard;
    logic [NREG-1:0] busy;
    logic [DW-1:0]   rf_in;
    logic [AW-1:0]   rf_inaddress;
    logic            rf_write;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               issue_load, issue_addr, rs1_addr, rs2_addr, rd_addr,
        input  alu_ready, mem_ready, hazard, busy, rf_in, rf_inaddress, rf_write
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               issue_load, issue_addr, rs1_addr, rs2_addr, rd_addr,
        output alu_ready, mem_ready, hazard, busy, rf_in, rf_inaddress, rf_write
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t buffering load results awaiting the write port.
//   CLK, RESET      : clock, synchronous active-low reset (drops all entries)
//   i_push, i_data  : enqueue request (ignored when full)
//   i_pop           : dequeue request (ignored when empty)
//   o_data          : head entry, valid while !o_empty
//   o_full, o_empty : occupancy flags
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int unsigned Depth = DEPTH
) (
    input  logic      CLK,
    input  logic      RESET,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;

    wb_entry_t     r_mem [Depth];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Shares the register file's single write port between ALU writeback and buffered
// load writeback. ALU has priority, but a load waiting through STARVE_LIMIT ALU wins
// is forced through. A busy scoreboard tracks destinations of outstanding loads.
//   CLK, RESET : clock, synchronous active-low reset
//   bus        : slave side of reg_wb_scheduler_if (requests, hazard, rf_* outputs)
module reg_wb_scheduler
    import reg_wb_pkg::*;
(
    input logic               CLK,
    input logic               RESET,
    reg_wb_scheduler_if.slave bus
);

    wb_entry_t        w_head;
    wb_entry_t        w_mem_entry;
    logic             w_full;
    logic             w_empty;
    logic             w_queue_grant;
    logic             w_alu_fire;
    logic [SCW-1:0]   w_starve_d;
    logic [NREG-1:0]  w_busy_d;

    logic             r_rf_write;
    logic [DW-1:0]    r_rf_in;
    logic [AW-1:0]    r_rf_inaddress;
    logic             r_src_mem;
    logic [SCW-1:0]   r_starve_cnt;
    logic [NREG-1:0]  r_busy;

    assign w_mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};

    wb_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (bus.mem_valid),
        .i_data  (w_mem_entry),
        .i_pop   (w_queue_grant),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Queue wins when the ALU is idle or the queue has been starved long enough.
    assign w_queue_grant = ~w_empty & (~bus.alu_valid | (r_starve_cnt == SCW'(STARVE_LIMIT)));
    assign w_alu_fire    = bus.alu_valid & ~w_queue_grant;

    assign bus.alu_ready    = ~w_queue_grant;
    assign bus.mem_ready    = ~w_full;
    assign bus.busy         = r_busy;
    assign bus.hazard       = r_busy[bus.rs1_addr] | r_busy[bus.rs2_addr] | r_busy[bus.rd_addr];
    assign bus.rf_in        = r_rf_in;
    assign bus.rf_inaddress = r_rf_inaddress;
    assign bus.rf_write     = r_rf_write;

    always_comb begin
        w_starve_d = r_starve_cnt;
        if (w_queue_grant) begin
            w_starve_d = '0;
        end else if (~w_empty & w_alu_fire & (r_starve_cnt != SCW'(STARVE_LIMIT))) begin
            w_starve_d = r_starve_cnt + 1'b1;
        end
    end

    // Clear lands on the same edge the register file captures the load; set applied last wins.
    always_comb begin
        w_busy_d = r_busy;
        if (r_rf_write & r_src_mem) w_busy_d[r_rf_inaddress] = 1'b0;
        if (bus.issue_load)         w_busy_d[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_rf_write     <= 1'b0;
            r_rf_in        <= '0;
            r_rf_inaddress <= '0;
            r_src_mem      <= 1'b0;
            r_starve_cnt   <= '0;
            r_busy         <= '0;
        end else begin
            r_rf_write   <= w_queue_grant | w_alu_fire;
            r_src_mem    <= w_queue_grant;
            r_starve_cnt <= w_starve_d;
            r_busy       <= w_busy_d;
            if (w_queue_grant) begin
                r_rf_in        <= w_head.data;
                r_rf_inaddress <= w_head.addr;
            end else if (w_alu_fire) begin
                r_rf_in        <= bus.alu_data;
                r_rf_inaddress <= bus.alu_addr;
            end
        end
    end

endmodule
